dram_ctrl_4164: RTL and testbench

Synchronous controller that drives one 8-chip 4164 DRAM bank (64K x 8) from a simple CPU-side request/acknowledge port. It multiplexes the 16-bit address onto the 8-bit l bus as row then column, and generates nras, ncas, nwe and the data-bus output enable. It also runs a RAS-only refresh engine. It sits between the memory mapper and the RAM bank.

---
 rtl/dram_ctrl_4164_if.sv | 14 +
 rtl/dram_ctrl_4164.sv | 177 +++++++++++++++++
 tb/tb_dram_ctrl_4164.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dram_ctrl_4164_if.sv
// CPU-side request/acknowledge bus of the 4164 DRAM controller.
// master = CPU / memory mapper, slave = controller.
interface dram_ctrl_4164_if;
  logic        req;
  logic        we;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ack;
  logic        busy;

  modport master (output req, we, addr, wdata, input rdata, ack, busy);
  modport slave  (input req, we, addr, wdata, output rdata, ack, busy);
endinterface

// File: rtl/dram_ctrl_4164.sv
// Controller for one 8-chip 4164 bank (64K x 8).
// Multiplexes row (addr[7:0]) then column (addr[15:8]) onto l and
// sequences nras/ncas/nwe/dram_oe. All outputs are registered.
// Optional macro DRAM_CTRL_REFRESH_EN adds the RAS-only refresh engine
// (interval counter, refresh row, ref_pending, REF state).
module dram_ctrl_4164 #(
  parameter int T_RCD        = 2,
  parameter int T_CAS        = 2,
  parameter int T_RP         = 2,
  parameter int REF_INTERVAL = 110
) (
  input  logic             clk,
  input  logic             rst,
  dram_ctrl_4164_if.slave  cpu,
  output logic [7:0]       l_o,
  output logic             nras_o,
  output logic             ncas_o,
  output logic             nwe_o,
  output logic [7:0]       dram_dout_o,
  output logic             dram_oe_o,
  input  logic [7:0]       dram_din_i
);

  localparam int CW = 16;

  typedef enum logic [2:0] {IDLE, ROW, COL, PRE, REF} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          we_q;
  logic [15:0]   addr_q;
  logic [7:0]    wdata_q;
  logic [7:0]    l_q, dout_q, rdata_q;
  logic          nras_q, ncas_q, nwe_q, oe_q, ack_q, busy_q;

  logic          ref_pending;
  logic          pend_d;
  logic          idle_d;
  logic          busy_d;

`ifdef DRAM_CTRL_REFRESH_EN
  logic [CW-1:0] ivl_q;
  logic [7:0]    rrow_q;
  logic          pend_q;
  logic          ref_wrap;
  logic          ref_start;

  assign ref_wrap    = (ivl_q == CW'(REF_INTERVAL - 1));
  assign ref_pending = pend_q;
  assign ref_start   = (state_q == IDLE) && pend_q;
  // A new wrap wins over the clear so a request landing on REF entry is kept.
  assign pend_d      = ref_wrap | (pend_q & ~ref_start);

  // Free-running refresh interval counter and the single pending flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      ivl_q  <= '0;
      pend_q <= 1'b0;
    end else begin
      ivl_q  <= ref_wrap ? '0 : ivl_q + CW'(1);
      pend_q <= pend_d;
    end
  end
`else
  assign ref_pending = 1'b0;
  assign pend_d      = 1'b0;
`endif

  // Next-cycle idleness, so busy can be registered in step with the state.
  always_comb begin
    idle_d = ((state_q == IDLE) && !ref_pending && !cpu.req) ||
             ((state_q == PRE) && (cnt_q == '0));
    busy_d = ~idle_d | pend_d;
  end

  // Main sequencer: state, phase counter and all registered pin values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      l_q     <= '0;
      nras_q  <= 1'b1;
      ncas_q  <= 1'b1;
      nwe_q   <= 1'b1;
      oe_q    <= 1'b0;
      dout_q  <= '0;
      ack_q   <= 1'b0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
`ifdef DRAM_CTRL_REFRESH_EN
      rrow_q  <= '0;
`endif
    end else begin
      ack_q  <= 1'b0;
      busy_q <= busy_d;
      case (state_q)
        IDLE: begin
`ifdef DRAM_CTRL_REFRESH_EN
          if (ref_pending) begin
            state_q <= REF;
            cnt_q   <= CW'(T_RCD + T_CAS - 1);
            l_q     <= rrow_q;
            nras_q  <= 1'b0;
          end else
`endif
          if (cpu.req) begin
            state_q <= ROW;
            cnt_q   <= CW'(T_RCD - 1);
            we_q    <= cpu.we;
            addr_q  <= cpu.addr;
            wdata_q <= cpu.wdata;
            l_q     <= cpu.addr[7:0];
            nras_q  <= 1'b0;
          end
        end
        ROW: begin
          if (cnt_q == '0) begin
            state_q <= COL;
            cnt_q   <= CW'(T_CAS - 1);
            l_q     <= addr_q[15:8];
            ncas_q  <= 1'b0;
            nwe_q   <= ~we_q;
            oe_q    <= we_q;
            dout_q  <= wdata_q;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        COL: begin
          if (cnt_q == '0) begin
            state_q <= PRE;
            cnt_q   <= CW'(T_RP - 1);
            nras_q  <= 1'b1;
            ncas_q  <= 1'b1;
            nwe_q   <= 1'b1;
            oe_q    <= 1'b0;
            ack_q   <= 1'b1;
            if (!we_q) rdata_q <= dram_din_i;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        PRE: begin
          if (cnt_q == '0) state_q <= IDLE;
          else             cnt_q   <= cnt_q - CW'(1);
        end
`ifdef DRAM_CTRL_REFRESH_EN
        REF: begin
          if (cnt_q == '0) begin
            state_q <= PRE;
            cnt_q   <= CW'(T_RP - 1);
            nras_q  <= 1'b1;
            rrow_q  <= rrow_q + 8'd1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cpu.rdata   = rdata_q;
  assign cpu.ack     = ack_q;
  assign cpu.busy    = busy_q;
  assign l_o         = l_q;
  assign nras_o      = nras_q;
  assign ncas_o      = ncas_q;
  assign nwe_o       = nwe_q;
  assign dram_dout_o = dout_q;
  assign dram_oe_o   = oe_q;

endmodule

// File: tb/tb_dram_ctrl_4164.sv
// Bench for dram_ctrl_4164: 4164 bank model on the pins, plus a
// transaction-level reference (activity kind + offset into its timeline)
// compared against every pin on every cycle.
module tb_dram_ctrl_4164;
  localparam int T_RCD = 2, T_CAS = 2, T_RP = 2, R = 110;
  localparam int T_ACT = T_RCD + T_CAS;
  localparam int T_TOT = T_ACT + T_RP;
`ifdef DRAM_CTRL_REFRESH_EN
  localparam bit REF_EN = 1'b1;
`else
  localparam bit REF_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dram_ctrl_4164_if cpu();
  logic [7:0] l, dout, din;
  logic       nras, ncas, nwe, oe;

  dram_ctrl_4164 #(.T_RCD(T_RCD), .T_CAS(T_CAS), .T_RP(T_RP), .REF_INTERVAL(R)) dut (
    .clk(clk), .rst(rst), .cpu(cpu),
    .l_o(l), .nras_o(nras), .ncas_o(ncas), .nwe_o(nwe),
    .dram_dout_o(dout), .dram_oe_o(oe), .dram_din_i(din)
  );

  // 4164 bank: row latched while RAS low / CAS high, write while both low.
  logic [7:0] bank [65536];
  logic [7:0] row_l = 8'h00;
  assign din = (!nras && !ncas) ? bank[{l, row_l}] : 8'h00;
  always @(negedge clk) begin
    if (!nras && ncas) row_l <= l;
    if (!nras && !ncas && !nwe) bank[{l, row_l}] <= dout;
  end

  // Reference: act 0 idle, 1 CPU access, 2 refresh; off = cycles into it.
  logic [7:0] ref_mem [65536];
  int         act, off, e;
  bit         pend;
  logic       m_we;
  logic [15:0] m_addr;
  logic [7:0] m_wd, m_rrow, m_refl, m_rdata;

  int n_cmp = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit wrap;
    if (rst) begin
      act = 0; off = 0; pend = 0; e = 0; m_rrow = 8'h00; m_rdata = 8'h00;
    end else begin
      e++;
      wrap = REF_EN && (e % R == 0);
      if (act == 0) begin
        if (pend) begin
          act = 2; off = 0; pend = 0; m_refl = m_rrow; m_rrow = m_rrow + 8'd1;
        end else if (cpu.req) begin
          act = 1; off = 0; m_we = cpu.we; m_addr = cpu.addr; m_wd = cpu.wdata;
        end
      end else begin
        off++;
        if (act == 1 && off == T_ACT && !m_we) m_rdata = ref_mem[m_addr];
        if (off == T_TOT) act = 0;
      end
      if (act == 1 && off == T_RCD && m_we) ref_mem[m_addr] = m_wd;
      if (wrap) pend = 1;
    end
  endtask

  task automatic check_cycle();
    logic [5:0] exp;  // {nras,ncas,nwe,oe,ack,busy}
    logic [7:0] el;
    bit         chk_l;
    exp = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    el = 8'h00; chk_l = 0;
    if (act == 1) begin
      if (off < T_RCD) begin
        exp[5] = 0; el = m_addr[7:0]; chk_l = 1;
      end else if (off < T_ACT) begin
        exp[5] = 0; exp[4] = 0; exp[3] = ~m_we; exp[2] = m_we; el = m_addr[15:8]; chk_l = 1;
      end else begin
        exp[1] = (off == T_ACT);
      end
    end else if (act == 2 && off < T_ACT) begin
      exp[5] = 0; el = m_refl; chk_l = 1;
    end
    exp[0] = (act != 0) || pend;
    chk("pins", {nras, ncas, nwe, oe, cpu.ack, cpu.busy}, exp);
    if (chk_l) chk("l", l, el);
    if (exp[2]) chk("dout", dout, m_wd);
    chk("rdata", cpu.rdata, m_rdata);
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_cycle();
  endtask

  // Holds req until the reference says ack; returns cycles from req to ack.
  task automatic access(input bit w, input logic [15:0] a, input logic [7:0] d, output int n);
    cpu.req = 1'b1; cpu.we = w; cpu.addr = a; cpu.wdata = d;
    n = 0;
    do begin step(); n++; end while (!(act == 1 && off == T_ACT) && n < 200);
    if (n >= 200) chk("ack_timeout", 32'd1, 32'd0);
    cpu.req = 1'b0;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] pool [8];
    logic [7:0] v;
    for (int i = 0; i < 65536; i++) begin
      v = 8'($urandom);
      bank[i] = v; ref_mem[i] = v;
    end
    for (int i = 0; i < 8; i++) pool[i] = 16'($urandom);
    cpu.req = 1'b1; cpu.we = 1'b1; cpu.addr = 16'h1234; cpu.wdata = 8'h55;

    // Reset held with req high: nothing may start.
    rst = 1'b1;
    repeat (3) step();
    chk("rst_l", l, 8'h00);
    chk("rst_dout", dout, 8'h00);
    cpu.req = 1'b0;
    rst = 1'b0;
    step();

    // Directed write then read-back of 0x3A5C.
    access(1'b1, 16'h3A5C, 8'hC3, n);
    chk("wr_lat", n, T_ACT + 1);
    step(); step();
    chk("bank_3a5c", bank[16'h3A5C], 8'hC3);
    access(1'b0, 16'h3A5C, 8'h00, n);
    chk("rd_lat", n, T_ACT + 1);
    chk("rd_3a5c", cpu.rdata, 8'hC3);
    repeat (3) step();

    // Reset in the middle of a write's column phase.
    cpu.req = 1'b1; cpu.we = 1'b1; cpu.addr = 16'hBEEF; cpu.wdata = 8'h5A;
    n = 0;
    do begin step(); n++; end while (!(act == 1 && off == T_RCD) && n < 200);
    if (n >= 200) chk("col_timeout", 32'd1, 32'd0);
    rst = 1'b1; cpu.req = 1'b0;
    step();
    chk("rst_mid_oe", oe, 1'b0);
    step();
    rst = 1'b0;
    step();
    access(1'b1, 16'hBEEF, 8'hA7, n);
    step(); step();
    access(1'b0, 16'hBEEF, 8'h00, n);
    chk("rd_beef", cpu.rdata, 8'hA7);
    step(); step();

    if (REF_EN) begin
      // Idle long enough for three refresh bursts.
      repeat (3 * R) step();
      // Collision: req raised in the cycle ref_pending becomes set.
      n = 0;
      while (!(act == 0 && pend && e % R == 0) && n < 4 * R) begin step(); n++; end
      if (n >= 4 * R) chk("coll_timeout", 32'd1, 32'd0);
      access(1'b0, pool[0], 8'h00, n);
      chk("coll_lat", n, T_ACT + T_RP + 1 + T_ACT + 1);
      // Enough refreshes to wrap the row counter past 0xFF.
      repeat (258 * R) step();
    end

    // Randomized traffic over a small address pool so reads hit writes.
    for (int i = 0; i < 150; i++) begin
      access(1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom), n);
      repeat ($urandom_range(0, 3)) step();
    end
    repeat (10) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
